// File: rtl/julia_pkg.sv
// Shared definitions for the frame-buffer SDRAM clients.
// Command encodings, address width and write-client FSM states.
package julia_pkg;

  localparam int ADDR_W = 22;

  localparam logic [1:0] CMD_IDLE  = 2'd0;
  localparam logic [1:0] CMD_WRITE = 2'd1;
  localparam logic [1:0] CMD_READ  = 2'd2;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_REQ,
    WR_WRITE
  } wr_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with occupancy count.
// A push while full is taken only when a pop frees the slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH     = 32,
  parameter int PTR_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic [WIDTH-1:0]     push_data,
  input  logic                 pop,
  output logic [WIDTH-1:0]     head,
  output logic [PTR_WIDTH:0]   count,
  output logic                 full
);

  localparam logic [PTR_WIDTH:0] DEPTH =
    {1'b1, {PTR_WIDTH{1'b0}}};

  logic [WIDTH-1:0]     mem [2**PTR_WIDTH];
  logic [PTR_WIDTH-1:0] wr_ptr;
  logic [PTR_WIDTH-1:0] rd_ptr;
  logic                 empty;
  logic                 do_push;
  logic                 do_pop;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Storage array, written on every accepted push.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy; simultaneous push and pop leave the count alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_WIDTH'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_WIDTH'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_WIDTH+1)'(1);
        2'b01:   count <= count - (PTR_WIDTH+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sdram_frame_writer.sv
// Write-side SDRAM client: buffers the pixel stream and writes it
// to the frame buffer in fixed bursts with raster-order addressing.
module sdram_frame_writer
  import julia_pkg::*;
#(
  parameter int X_PX           = 800,
  parameter int Y_PX           = 480,
  parameter int FRAME_BASE     = 0,
  parameter int BURST_LENGTH   = 8,
  parameter int FIFO_PTR_WIDTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       pix_data,
  input  logic              pix_valid,
  input  logic              pix_sof,
  output logic              pix_ready,
  output logic              wr_request,
  input  logic              wr_grant,
  output logic [1:0]        command,
  output logic [ADDR_W-1:0] data_address,
  output logic [31:0]       data_write,
  input  logic              data_write_done,
  output logic              frame_done,
  output logic              sync_error
);

  localparam int TOTAL = X_PX * Y_PX;
  localparam int CNT_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam int CW    = FIFO_PTR_WIDTH + 1;
  localparam int CD_W  =
    (BURST_LENGTH > 1) ? $clog2(BURST_LENGTH) : 1;

  localparam logic [ADDR_W-1:0] BASE =
    ADDR_W'(FRAME_BASE);
  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(FRAME_BASE + TOTAL - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST =
    CNT_W'(TOTAL - 1);
  localparam logic [CW-1:0]     BURST_CNT =
    CW'(BURST_LENGTH);
  localparam logic [CD_W-1:0]   CD_INIT =
    CD_W'(BURST_LENGTH - 1);

  logic              accept;
  logic              fifo_full;
  logic              pop;
  logic [31:0]       head;
  logic [CW-1:0]     fifo_count;
  logic [CNT_W-1:0]  in_cnt;

  wr_state_t         state;
  wr_state_t         state_n;
  logic [1:0]        command_n;
  logic              wr_request_n;
  logic [ADDR_W-1:0] address_n;
  logic [31:0]       data_n;
  logic [CD_W-1:0]   countdown;
  logic [CD_W-1:0]   countdown_n;
  logic              frame_done_n;

  assign pix_ready = !fifo_full;
  assign accept    = pix_valid && pix_ready;

  sync_fifo #(
    .WIDTH     (32),
    .PTR_WIDTH (FIFO_PTR_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (accept),
    .push_data (pix_data),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count),
    .full      (fifo_full)
  );

  // Raster position of the next accepted pixel; sof never realigns it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_cnt     <= '0;
      sync_error <= 1'b0;
    end else begin
      sync_error <= accept && pix_sof && (in_cnt != '0);
      if (accept) begin
        in_cnt <= (in_cnt == CNT_LAST) ? '0
                                       : in_cnt + CNT_W'(1);
      end
    end
  end

  // Burst sequencer: next state, outputs, pops and address stepping.
  always_comb begin
    state_n      = state;
    command_n    = command;
    wr_request_n = wr_request;
    address_n    = data_address;
    data_n       = data_write;
    countdown_n  = countdown;
    frame_done_n = 1'b0;
    pop          = 1'b0;
    unique case (state)
      WR_IDLE: begin
        if (fifo_count >= BURST_CNT) begin
          state_n      = WR_REQ;
          wr_request_n = 1'b1;
        end
      end
      WR_REQ: begin
        if (wr_grant) begin
          state_n     = WR_WRITE;
          command_n   = CMD_WRITE;
          data_n      = head;
          pop         = 1'b1;
          countdown_n = CD_INIT;
        end
      end
      WR_WRITE: begin
        if (data_write_done) begin
          if (data_address == LAST) begin
            address_n    = BASE;
            frame_done_n = 1'b1;
          end else begin
            address_n = data_address + ADDR_W'(1);
          end
          if (countdown == '0) begin
            state_n      = WR_IDLE;
            command_n    = CMD_IDLE;
            wr_request_n = 1'b0;
          end else begin
            countdown_n = countdown - CD_W'(1);
            data_n      = head;
            pop         = 1'b1;
          end
        end
      end
      default: begin
        state_n = WR_IDLE;
      end
    endcase
  end

  // Sequencer registers; reset aborts any burst in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= WR_IDLE;
      command      <= CMD_IDLE;
      wr_request   <= 1'b0;
      data_address <= BASE;
      data_write   <= '0;
      countdown    <= '0;
      frame_done   <= 1'b0;
    end else begin
      state        <= state_n;
      command      <= command_n;
      wr_request   <= wr_request_n;
      data_address <= address_n;
      data_write   <= data_n;
      countdown    <= countdown_n;
      frame_done   <= frame_done_n;
    end
  end

endmodule
